// File: rtl/pulse_train_tx_pkg.sv
// Shared types and widths for the pulse_train_tx transmit block.
package pulse_train_tx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, GAP = 2'd2} tx_state_t;
  localparam int TIMER_W = 8;
  localparam int PEND_W  = 4;
endpackage

// File: rtl/pulse_train_timer.sv
// Loadable down-counter that times both the HIGH and GAP phases; holds at zero.
module pulse_train_timer
  import pulse_train_tx_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               zero_o
);
  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/pulse_train_tx.sv
// Stretches trigger strobes into width/gap-guaranteed pulses with a pending queue.
// Optional macro PULSE_TRAIN_TX_ACTIVE_LOW_EN: pulse_out idles high and asserts low.
module pulse_train_tx
  import pulse_train_tx_pkg::*;
#(
  parameter int PULSE_WIDTH = 4,
  parameter int GAP_WIDTH   = 4,
  parameter int MAX_PENDING = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  output logic              pulse_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);
  if (PULSE_WIDTH < 1 || PULSE_WIDTH > 255) begin : g_bad_pulse_width
    $error("pulse_train_tx: PULSE_WIDTH must be 1..255");
  end
  if (GAP_WIDTH < 1 || GAP_WIDTH > 255) begin : g_bad_gap_width
    $error("pulse_train_tx: GAP_WIDTH must be 1..255");
  end
  if (MAX_PENDING < 1 || MAX_PENDING > 15) begin : g_bad_max_pending
    $error("pulse_train_tx: MAX_PENDING must be 1..15");
  end

  localparam logic [TIMER_W-1:0] PW_LOAD  = TIMER_W'(PULSE_WIDTH - 1);
  localparam logic [TIMER_W-1:0] GW_LOAD  = TIMER_W'(GAP_WIDTH - 1);
  localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(MAX_PENDING);

`ifdef PULSE_TRAIN_TX_ACTIVE_LOW_EN
  localparam logic PULSE_ON  = 1'b0;
  localparam logic PULSE_OFF = 1'b1;
`else
  localparam logic PULSE_ON  = 1'b1;
  localparam logic PULSE_OFF = 1'b0;
`endif

  tx_state_t          state_q, state_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               pulse_q, pulse_d;
  logic               tmr_load, tmr_zero, drop;
  logic [TIMER_W-1:0] tmr_val;

  pulse_train_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      pulse_q <= PULSE_OFF;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
    end
  end

  // A trigger landing on the GAP end is absorbed by the dequeue, so it never drops.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    tmr_load = 1'b0;
    tmr_val  = PW_LOAD;
    drop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d  = HIGH;
          tmr_load = 1'b1;
        end
      end
      HIGH, GAP: begin
        if (state_q == GAP && tmr_zero) begin
          if (pend_q != '0 || trig) begin
            state_d  = HIGH;
            tmr_load = 1'b1;
            pend_d   = trig ? pend_q : pend_q - 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (state_q == HIGH && tmr_zero) begin
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = GW_LOAD;
          end
          if (trig) begin
            if (pend_q < PEND_MAX) pend_d = pend_q + 1'b1;
            else                   drop   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pulse_d  = (state_d == HIGH) ? PULSE_ON : PULSE_OFF;
    busy     = (state_q != IDLE) || (pend_q != '0);
    overflow = drop & ~rst;
  end

  assign pulse_out = pulse_q;
  assign pending   = pend_q;
endmodule

// File: tb/tb_pulse_train_tx.sv
// Scoreboard bench for pulse_train_tx: a schedule-of-pulse-starts model predicts every cycle.
module tb_pulse_train_tx;
  localparam int PW   = 4;
  localparam int GW   = 4;
  localparam int MAXP = 3;
`ifdef PULSE_TRAIN_TX_ACTIVE_LOW_EN
  localparam logic ASSERT_LVL = 1'b0;
`else
  localparam logic ASSERT_LVL = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic       pulse_out, busy, overflow;
  logic [3:0] pending;

  pulse_train_tx #(.PULSE_WIDTH(PW), .GAP_WIDTH(GW), .MAX_PENDING(MAXP)) dut (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .pulse_out (pulse_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic p;
    logic b;
    logic [3:0] pend;
    logic ov;
  } exp_t;

  exp_t sb[$];
  int   starts[$];   // cycle numbers at which accepted pulses begin
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   npulse = 0;
  logic prev_lvl = 1'bx;

  task automatic check(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, c, act, exp);
    end
  endtask

  // Outputs visible during cycle c, derived only from the schedule of pulse starts.
  function automatic void model_outputs(input int c, output bit p, output bit b, output int pd);
    p = 0; b = 0; pd = 0;
    foreach (starts[i]) begin
      if (starts[i] <= c && c < starts[i] + PW)      p = 1;
      if (starts[i] <= c && c < starts[i] + PW + GW) b = 1;
      if (starts[i] > c)                             pd++;
    end
    if (pd > 0) b = 1;
  endfunction

  task automatic step(input logic t, input logic r);
    exp_t e;
    bit   p, b, ov, gap_end;
    int   pd, cur;
    @(posedge clk); #1;
    cyc++;
    trig = t;
    rst  = r;
    model_outputs(cyc, p, b, pd);
    ov = 0;
    if (r) begin
      starts.delete();
    end else if (t) begin
      if (!b) begin
        starts.push_back(cyc + 1);
      end else begin
        cur = -1;
        foreach (starts[i]) if (starts[i] <= cyc) cur = starts[i];
        gap_end = (cur >= 0) && (cyc == cur + PW + GW - 1);
        if (gap_end || pd < MAXP) starts.push_back(starts[$] + PW + GW);
        else ov = 1;
      end
    end
    e.cyc = cyc; e.p = p; e.b = b; e.pend = 4'(pd); e.ov = ov;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pulse_out === ASSERT_LVL && prev_lvl !== ASSERT_LVL) npulse++;
    prev_lvl = pulse_out;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pulse_out", e.cyc, {7'd0, pulse_out}, {7'd0, (e.p ? ASSERT_LVL : ~ASSERT_LVL)});
      check("busy",      e.cyc, {7'd0, busy},      {7'd0, e.b});
      check("pending",   e.cyc, {4'd0, pending},   {4'd0, e.pend});
      check("overflow",  e.cyc, {7'd0, overflow},  {7'd0, e.ov});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, prob;
    repeat (2) @(posedge clk);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle(3);

    // single event
    n0 = npulse;
    step(1'b1, 1'b0);
    idle(20);
    check("single_pulse_count", cyc, 8'(npulse - n0), 8'd1);

    // back-to-back
    n0 = npulse;
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    idle(25);
    check("b2b_pulse_count", cyc, 8'(npulse - n0), 8'd2);

    // held trigger saturates the queue
    n0 = npulse;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    idle(40);
    check("overflow_pulse_count", cyc, 8'(npulse - n0), 8'd4);

    // trigger coinciding with the dequeue at the end of the first gap
    n0 = npulse;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    idle(PW + GW - 4);
    step(1'b1, 1'b0);
    idle(50);
    check("collision_pulse_count", cyc, 8'(npulse - n0), 8'd5);

    // reset in HIGH with two queued
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    idle(3);
    n0 = npulse;
    step(1'b1, 1'b0);
    idle(15);
    check("post_reset_pulse_count", cyc, 8'(npulse - n0), 8'd1);

    // randomized traffic with varying density and occasional reset
    prob = 30;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        case ($urandom_range(3))
          0: prob = 5;
          1: prob = 30;
          2: prob = 70;
          default: prob = 95;
        endcase
      end
      step(($urandom_range(99) < prob) ? 1'b1 : 1'b0, ($urandom_range(299) == 0) ? 1'b1 : 1'b0);
    end
    idle(60);

    @(negedge clk); #1;
    check("scoreboard_drained", cyc, 8'(sb.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
